// File: rtl/alu_pkg.sv
// Opcode encodings and default datapath widths shared by the ALU arbiter slice.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  localparam int unsigned W   = 16;
  localparam int unsigned IDW = 2;

endpackage

// File: rtl/alu16_core.sv
// Combinational ALU datapath: bitwise AND/OR/XOR plus a modulo-2^W adder.
module alu16_core #(
  parameter int unsigned W = alu_pkg::W
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  import alu_pkg::*;

  logic [W-1:0] and_y;
  logic [W-1:0] or_y;
  logic [W-1:0] xor_y;
  logic [W-1:0] add_y;

  assign and_y = a & b;
  assign or_y  = a | b;
  assign xor_y = a ^ b;
  // Carry-out intentionally dropped: sum wraps at W bits.
  assign add_y = a + b;

  always_comb begin
    y = and_y;
    case (op)
      OP_AND:  y = and_y;
      OP_OR:   y = or_y;
      OP_XOR:  y = xor_y;
      OP_ADD:  y = add_y;
      default: y = and_y;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, with a single
// registered result slot on a valid/ready response handshake.
module alu_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = alu_pkg::W,
  parameter int unsigned IDW  = alu_pkg::IDW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [W*NREQ-1:0]   req_a,
  input  logic [W*NREQ-1:0]   req_b,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [W-1:0]        resp_y,
  output logic                resp_zero,
  output logic                busy
);
  import alu_pkg::*;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic           state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [W-1:0]   resp_y_q, resp_y_d;
  logic           resp_zero_q, resp_zero_d;

  logic [NREQ-1:0] rot;
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  next_ptr;
  logic            slot_free;
  logic            accept;
  logic [1:0]      sel_op;
  logic [W-1:0]    sel_a, sel_b, alu_y;

  assign slot_free = (state_q == ST_EMPTY) || resp_ready;

  // Rotate so bit 0 is the requester at rr_ptr; first set bit wins.
  always_comb begin
    int unsigned pos;
    rot         = NREQ'({req_valid, req_valid} >> rr_ptr_q);
    grant_found = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_found && rot[k]) begin
        grant_found = 1'b1;
        pos         = 32'(rr_ptr_q) + k;
        if (pos >= NREQ) pos = pos - NREQ;
        grant_idx   = IDW'(pos);
      end
    end
  end

  // Gated by rst_n so no handshake can complete while reset is held.
  assign accept = grant_found && slot_free && rst_n;

  always_comb begin
    req_ready = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        req_ready[k] = accept;
        sel_op       = req_op[2*k +: 2];
        sel_a        = req_a[W*k +: W];
        sel_b        = req_b[W*k +: W];
      end
    end
  end

  alu16_core #(.W(W)) u_alu (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (alu_y)
  );

  assign next_ptr = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    resp_id_d   = resp_id_q;
    resp_y_d    = resp_y_q;
    resp_zero_d = resp_zero_q;
    if (accept) begin
      state_d     = ST_FULL;
      rr_ptr_d    = next_ptr;
      resp_id_d   = grant_idx;
      resp_y_d    = alu_y;
      resp_zero_d = (alu_y == '0);
    end else if (resp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      rr_ptr_q    <= '0;
      resp_id_q   <= '0;
      resp_y_q    <= '0;
      resp_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      resp_id_q   <= resp_id_d;
      resp_y_q    <= resp_y_d;
      resp_zero_q <= resp_zero_d;
    end
  end

  assign resp_valid = (state_q == ST_FULL);
  assign resp_id    = resp_id_q;
  assign resp_y     = resp_y_q;
  assign resp_zero  = resp_zero_q;
  assign busy       = resp_valid && !resp_ready;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench: behavioural reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alu_rr_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a, req_b;
  logic              resp_valid, resp_ready, resp_zero, busy;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_zero  (resp_zero),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: begin
        s = {1'b0, a} + {1'b0, b};
        return s[W-1:0];
      end
    endcase
  endfunction

  // Reference model state (current and next)
  logic         m_valid = 1'b0, m_zero = 1'b0;
  int           m_id = 0, m_ptr = 0;
  logic [W-1:0] m_y = '0;
  logic         n_valid = 1'b0, n_zero = 1'b0;
  int           n_id = 0, n_ptr = 0;
  logic [W-1:0] n_y = '0;

  always @(negedge clk) begin
    int best;
    int bestd;
    int d;
    logic [NREQ-1:0] er;
    logic free;
    free  = !m_valid || resp_ready;
    best  = -1;
    bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        d = (i - m_ptr + NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    er = '0;
    if (rst_n && free && best >= 0) er[best] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), 32'(m_valid));
    chk("resp_id", 32'(resp_id), m_id);
    chk("resp_y", 32'(resp_y), 32'(m_y));
    chk("resp_zero", 32'(resp_zero), 32'(m_zero));
    chk("busy", 32'(busy), 32'(m_valid && !resp_ready));
    n_valid = m_valid; n_id = m_id; n_y = m_y; n_zero = m_zero; n_ptr = m_ptr;
    if (er != '0) begin
      n_valid = 1'b1;
      n_id    = best;
      n_y     = ref_alu(req_op[2*best +: 2], req_a[W*best +: W], req_b[W*best +: W]);
      n_zero  = (n_y == '0);
      n_ptr   = (best + 1) % NREQ;
    end else if (resp_ready) begin
      n_valid = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_id = 0; m_y = '0; m_zero = 1'b0; m_ptr = 0;
    end else begin
      m_valid = n_valid; m_id = n_id; m_y = n_y; m_zero = n_zero; m_ptr = n_ptr;
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[2*i +: 2] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int            exp_id[5]   = '{0, 1, 2, 3, 0};
  logic [W-1:0]  exp_y[5]    = '{16'h000F, 16'h00FF, 16'h0000, 16'h0000, 16'h000F};
  logic          exp_z[5]    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [NREQ-1:0] rr_seq[4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0100};

  initial begin
    logic [W-1:0] pick;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_valid", 32'(resp_valid), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_y", 32'(resp_y), 32'h0000);
    end

    step();
    set_req(0, 2'b10, 16'hFFFF, 16'hAAAA);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", 32'(resp_valid), 32'd1);
    chk("single_id", 32'(resp_id), 32'd0);
    chk("single_y", 32'(resp_y), 32'h5555);
    chk("single_zero", 32'(resp_zero), 32'd0);

    reset_pulse();
    set_req(0, 2'b00, 16'h00FF, 16'h0F0F);
    set_req(1, 2'b01, 16'h00F0, 16'h000F);
    set_req(2, 2'b10, 16'h5555, 16'h5555);
    set_req(3, 2'b11, 16'hFFFF, 16'h0001);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("all4_grant", 32'(req_ready), 32'(1) << exp_id[k]);
      if (k > 0) begin
        chk("all4_id", 32'(resp_id), exp_id[k-1]);
        chk("all4_y", 32'(resp_y), 32'(exp_y[k-1]));
        chk("all4_zero", 32'(resp_zero), 32'(exp_z[k-1]));
      end
    end

    step();
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_id", 32'(resp_id), 32'd0);
      chk("bp_y", 32'(resp_y), 32'h000F);
    end
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("bp_result_id", 32'(resp_id), 32'd1);
    chk("bp_result_y", 32'(resp_y), 32'h00FF);

    step();
    req_valid = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_wrap", 32'(req_ready), 32'(rr_seq[k]));
    end
    step();
    resp_ready = 1'b0;
    req_valid  = '0;
    @(negedge clk);
    chk("pre_reset_full", 32'(resp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear_valid", 32'(resp_valid), 32'd0);
    chk("async_clear_busy", 32'(busy), 32'd0);
    chk("async_clear_y", 32'(resp_y), 32'h0000);
    step();
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 4'b0101;
    @(negedge clk);
    chk("post_reset_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("post_reset_next", 32'(req_ready), 32'b0100);
    chk("post_reset_id", 32'(resp_id), 32'd0);

    for (int n = 0; n < 400; n++) begin
      step();
      if (n == 200) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      req_valid  = NREQ'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0: pick = '0;
          1: pick = '1;
          default: pick = W'($urandom);
        endcase
        set_req(i, 2'($urandom), pick, W'($urandom));
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
